// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, scale encodings and period helpers for the VGA raster generator.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Encoding value doubles as the coordinate right-shift amount.
   typedef enum logic [1:0] {
      SCALE_1X = 2'd0,
      SCALE_2X = 2'd1,
      SCALE_4X = 2'd2
   } scale_e;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic scale_e scale_decode(input logic [1:0] sel);
      scale_e res;
      case (sel)
         2'd0:    res = SCALE_1X;
         2'd1:    res = SCALE_2X;
         default: res = SCALE_4X;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and sync-window decode.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int   ACTIVE = DEF_H_ACTIVE,
   parameter int   FP     = DEF_H_FP,
   parameter int   SYNC   = DEF_H_SYNC,
   parameter int   BP     = DEF_H_BP,
   parameter logic POL    = 1'b0,
   parameter int   CW     = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          in_active,
   output logic          sync_lvl
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);
   // One extra bit so the window ends stay representable when BP is zero.
   localparam logic [CW:0]   ACT_END  = (CW+1)'(ACTIVE);
   localparam logic [CW:0]   SYNC_BEG = (CW+1)'(ACTIVE + FP);
   localparam logic [CW:0]   SYNC_END = (CW+1)'(ACTIVE + FP + SYNC);

   logic [CW-1:0] count_r;
   logic [CW:0]   count_ext_s;

   // Position along the axis; advances on step and returns to zero after the last position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else if (step) begin
         if (count_r == LAST) begin
            count_r <= {CW{1'b0}};
         end else begin
            count_r <= count_r + ONE;
         end
      end
   end

   assign count_ext_s = {1'b0, count_r};
   assign count       = count_r;
   assign wrap        = step && (count_r == LAST);
   assign in_active   = (count_ext_s < ACT_END);
   assign sync_lvl    = ((count_ext_s >= SYNC_BEG) && (count_ext_s < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered, mutually aligned sync/active/coordinate outputs.
// Optional coordinate scaling is built when VGA_TIMING_SCALE_EN is defined.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FP      = DEF_V_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   CW        = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
`ifdef VGA_TIMING_SCALE_EN
   input  logic [1:0]    scale,
`endif
   output logic          h_sync_o,
   output logic          v_sync_o,
   output logic          active_o,
   output logic [CW-1:0] posx,
   output logic [CW-1:0] posy,
   output logic          line_start,
   output logic          frame_start
);

   logic [CW-1:0] h_cnt_s, v_cnt_s, posx_s, posy_s;
   logic          h_wrap_s, h_act_s, h_sync_s;
   logic          v_wrap_s, v_act_s, v_sync_s;
   logic [1:0]    scale_sel_s, shift_s;
   scale_e        scale_r;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL), .CW(CW)
   ) u_h_axis (
      .clk(clk), .rst(rst), .step(en),
      .count(h_cnt_s), .wrap(h_wrap_s), .in_active(h_act_s), .sync_lvl(h_sync_s)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL), .CW(CW)
   ) u_v_axis (
      .clk(clk), .rst(rst), .step(h_wrap_s),
      .count(v_cnt_s), .wrap(v_wrap_s), .in_active(v_act_s), .sync_lvl(v_sync_s)
   );

`ifdef VGA_TIMING_SCALE_EN
   assign scale_sel_s = scale;
`else
   assign scale_sel_s = SCALE_1X;
`endif

   // Scale only changes on the edge that wraps to (0,0), so a frame never mixes scales.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scale_r <= SCALE_1X;
      end else if (v_wrap_s) begin
         scale_r <= scale_decode(scale_sel_s);
      end
   end

   assign shift_s = scale_r;
   assign posx_s  = h_act_s ? (h_cnt_s >> shift_s) : {CW{1'b0}};
   assign posy_s  = v_act_s ? (v_cnt_s >> shift_s) : {CW{1'b0}};

   // Output stage: registers the decode of the pre-increment counters; strobes clear when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_sync_o    <= ~HSYNC_POL;
         v_sync_o    <= ~VSYNC_POL;
         active_o    <= 1'b0;
         posx        <= {CW{1'b0}};
         posy        <= {CW{1'b0}};
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         h_sync_o    <= h_sync_s;
         v_sync_o    <= v_sync_s;
         active_o    <= h_act_s && v_act_s;
         posx        <= posx_s;
         posy        <= posy_s;
         line_start  <= (h_cnt_s == {CW{1'b0}});
         frame_start <= (h_cnt_s == {CW{1'b0}}) && (v_cnt_s == {CW{1'b0}});
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule
